// File: rtl/walls_tile_drawer.sv
// walls_tile_drawer
// Draws destructible walls on a 20x15 grid of 32x32 tiles and keeps the
// per-tile wall map that explosions clear through a queued destroy interface.
// Queued destroy requests are applied only after startOfFrame, during the
// vertical blank, so a wall never vanishes halfway through a frame.
//
// Ports:
//   clk, resetN                 clock, asynchronous active-low reset
//   startOfFrame                one-cycle pulse at start of vertical blank
//   pixelX, pixelY              current pixel coordinates
//   destroyValid/TileX/TileY    destroy request (tile column/row)
//   destroyReady                request FIFO can accept a request
//   destroyDone, destroyHadWall one-cycle pulse per applied request, and
//                               whether the tile held a wall at that point
//   wallCount                   number of walls currently present
//   wallsDR, wallsRGB           draw request and RGB332 colour (1-cycle latency)
module walls_tile_drawer #(
  parameter logic [7:0] WALL_COLOR   = 8'hB4,
  parameter logic [7:0] BORDER_COLOR = 8'h6C,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        destroyValid,
  input  logic [4:0]  destroyTileX,
  input  logic [3:0]  destroyTileY,
  output logic        destroyReady,
  output logic        destroyDone,
  output logic        destroyHadWall,
  output logic [8:0]  wallCount,
  output logic        wallsDR,
  output logic [7:0]  wallsRGB
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [8:0] INIT_WALLS = 9'd58;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_APPLY = 1'b1} state_t;

  // Start-up wall layout: interior tiles on the (c+r)%3 diagonals, minus the
  // even/even pillar positions and the player's top-left spawn corner.
  function automatic logic [299:0] initial_map();
    logic [299:0] m;
    logic [8:0]   idx;
    m = '0;
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 20; c++) begin
        idx = 9'(r * 20 + c);
        if (c >= 1 && c <= 18 && r >= 1 && r <= 13 &&
            !((c % 2 == 0) && (r % 2 == 0)) &&
            ((c + r) % 3 == 0) && !(c <= 2 && r <= 2)) begin
          m[idx] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  // Row-major tile index into the 300-bit wall map.
  function automatic logic [8:0] tile_index(input logic [4:0] x, input logic [3:0] y);
    return 9'(y) * 9'd20 + 9'(x);
  endfunction

  state_t              state_r, state_next_s;
  logic [299:0]        map_r;
  logic [8:0]          wall_count_r;
  logic                done_r, had_wall_r, ready_r;
  logic                draw_r;
  logic [7:0]          rgb_r;
  logic [8:0]          fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    count_r, count_next_s;
  logic                push_s, pop_s;
  logic [8:0]          head_s;
  logic                head_in_range_s, head_hit_s;
  logic [8:0]          head_idx_s;
  logic                px_in_range_s, px_wall_s, px_edge_s;
  logic [8:0]          px_idx_s;

  assign push_s          = destroyValid && ready_r;
  assign head_s          = fifo_mem_r[rd_ptr_r];
  assign head_in_range_s = (head_s[4:0] < 5'd20) && (head_s[8:5] < 4'd15);
  assign head_idx_s      = tile_index(head_s[4:0], head_s[8:5]);
  // Out-of-range entries must not index the map (row 15 would alias past bit 299).
  assign head_hit_s      = head_in_range_s && map_r[head_idx_s];

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Destroy FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {destroyTileY, destroyTileX};
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ready_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_next_s;
      ready_r <= (count_next_s != CNT_FULL);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_r <= ST_IDLE;
    else         state_r <= state_next_s;
  end

  // FSM next-state: leave IDLE only on a frame start with work queued; keep
  // applying while entries remain, including ones pushed during APPLY.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (startOfFrame && (count_r != CNT_ZERO)) state_next_s = ST_APPLY;
        else                                       state_next_s = ST_IDLE;
      end
      ST_APPLY: begin
        if (count_next_s != CNT_ZERO) state_next_s = ST_APPLY;
        else                          state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs: one pop per APPLY cycle.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_APPLY: pop_s = (count_r != CNT_ZERO);
      default:  pop_s = 1'b0;
    endcase
  end

  // Wall map, wall counter and completion reporting.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      map_r        <= initial_map();
      wall_count_r <= INIT_WALLS;
      done_r       <= 1'b0;
      had_wall_r   <= 1'b0;
    end else begin
      done_r     <= pop_s;
      had_wall_r <= pop_s && head_hit_s;
      if (pop_s && head_hit_s) begin
        map_r[head_idx_s] <= 1'b0;
        if (wall_count_r != 9'd0) wall_count_r <= wall_count_r - 9'd1;
      end
    end
  end

  assign px_in_range_s = (pixelX < 11'd640) && (pixelY < 11'd480);
  assign px_idx_s      = tile_index(pixelX[9:5], pixelY[8:5]);
  assign px_wall_s     = px_in_range_s && map_r[px_idx_s];
  assign px_edge_s     = (pixelX[4:0] == 5'd0) || (pixelX[4:0] == 5'd31) ||
                         (pixelY[4:0] == 5'd0) || (pixelY[4:0] == 5'd31);

  // Registered pixel path.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      draw_r <= 1'b0;
      rgb_r  <= 8'h00;
    end else if (px_wall_s) begin
      draw_r <= 1'b1;
      rgb_r  <= px_edge_s ? BORDER_COLOR : WALL_COLOR;
    end else begin
      draw_r <= 1'b0;
      rgb_r  <= 8'h00;
    end
  end

  assign destroyReady   = ready_r;
  assign destroyDone    = done_r;
  assign destroyHadWall = had_wall_r;
  assign wallCount      = wall_count_r;
  assign wallsDR        = draw_r;
  assign wallsRGB       = rgb_r;

endmodule
